piece_draw_engine: RTL and testbench
====================================

PIECE_DRAW_ENGINE -- requirements
Module: piece_draw_engine

Interface
REQ-001 SHALL have parameter ORIGIN_X, default 8'd20, the board's left pixel x.
REQ-002 SHALL have parameter ORIGIN_Y, default 7'd20, the board's top pixel y (row 0).
REQ-003 SHALL have parameter PITCH, default 8, the cell-to-cell pixel spacing in x and y.
REQ-004 SHALL have parameter CELL, default 4, the drawn square side in pixels; pixel counter width is clog2(CELL*CELL) (4 bits at default).
REQ-005 SHALL have port clk, input, 1, the system clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1, reset: synchronous, active-low.
REQ-007 SHALL have port req_valid, input, 1, draw request present.
REQ-008 SHALL have port req_ready, output, 1, the engine accepts a request this cycle.
REQ-009 SHALL have port req_col, input, 3, board column 0..6.
REQ-010 SHALL have port req_row, input, 3, board row 0..5 (0 = top).
REQ-011 SHALL have port req_kind, input, 1, 0 = grid piece, 1 = pointer above column (row ignored).
REQ-012 SHALL have port req_colour, input, 3, RGB colour to draw.
REQ-013 SHALL have ports x (output, 8), y (output, 7), colour (output, 3) and plot (output, 1), the VGA adapter write port.
REQ-014 SHALL have port done, output, 1, a one-cycle pulse when a request completes.
REQ-015 SHALL have port err, output, 1, a one-cycle pulse when a request is out of range.

Function
REQ-016 SHALL implement FSM states IDLE, DRAW and FINISH.
REQ-017 SHALL drive req_ready=1 only in IDLE; a handshake occurs on a rising edge where req_valid and req_ready are both 1.
REQ-018 SHALL, on handshake, latch base_x=ORIGIN_X+col*PITCH, base_y=(kind ? ORIGIN_Y-PITCH : ORIGIN_Y+row*PITCH) and colour.
REQ-019 SHALL compute base_x and base_y at full output width, with no wrap checking beyond REQ-020.
REQ-020 SHALL treat col>6, or kind=0 with row>5, as invalid: go to FINISH, never assert plot, and pulse err together with done.
REQ-021 SHALL, in DRAW, emit one pixel per cycle with registered outputs: x=base_x+(cnt mod CELL), y=base_y+(cnt div CELL), plot=1.
REQ-022 SHALL make the latency deterministic: handshake at edge k; plot high for cycles k+1..k+CELL*CELL; done high in cycle k+CELL*CELL+1 (k+17 at default).
REQ-023 SHALL, when cnt==CELL*CELL-1, clear the counter and move to FINISH; it SHALL NOT wrap back to DRAW.
REQ-024 SHALL keep plot=0 in IDLE and FINISH, and hold x, y and colour at their last values.
REQ-025 SHALL, in FINISH, pulse done for exactly one cycle and then return to IDLE.
REQ-026 SHALL ignore req_* inputs while not in IDLE, so a request held high is accepted on the first IDLE cycle after FINISH.

Reset
REQ-027 SHALL, with resetn=0 at a rising edge, set the state to IDLE, cnt=0, plot=0, done=0, err=0, x=0, y=0, colour=0 and req_ready=1 after that edge.
REQ-028 SHALL treat reset mid-DRAW as an abort: no done pulse, plot=0 from the next cycle, and the remaining pixels are not drawn.

Configuration
REQ-029 SHALL support macro PIECE_ROUND_CORNERS_EN; when defined, plot SHALL be 0 on the four corner pixels of each square (cnt 0, CELL-1, CELL*CELL-CELL, CELL*CELL-1), while the counter still traverses every pixel.
REQ-030 SHALL keep timing unchanged with PIECE_ROUND_CORNERS_EN defined: 12 plots at default, done still at k+17.
REQ-031 SHALL, without PIECE_ROUND_CORNERS_EN, plot all CELL*CELL pixels.

Verification (defaults)
REQ-032 SHALL verify: col=0, row=0, kind=0, colour=3'b100 -> 16 plots covering x 20..23, y 20..23, raster order, colour 100; done at k+17.
REQ-033 SHALL verify: col=6, row=5 -> x 68..71, y 60..63; kind=1, col=3 -> x 44..47, y 12..15.
REQ-034 SHALL verify: col=7 -> zero plots; err and done pulse together at k+1; req_ready=1 at k+2.
REQ-035 SHALL verify: resetn=0 asserted after the 5th plot -> plot=0 next cycle, no done, req_ready=1; a new request then draws all 16 pixels.
REQ-036 SHALL verify: req_valid held high with two requests -> second handshake at k+18 edge; plot gap of exactly two cycles (FINISH, IDLE) between squares.
REQ-037 SHALL verify: with PIECE_ROUND_CORNERS_EN defined, col=0, row=0 -> 12 plots, none at (20,20), (23,20), (20,23) or (23,23); done at k+17.

Source files
------------

// File: rtl/piece_draw_engine.sv
// piece_draw_engine: rasterises one board square (grid piece or column
// pointer) into the VGA adapter write port, one pixel per clock.
// Optional build macro PIECE_ROUND_CORNERS_EN suppresses plotting of the four
// corner pixels of every square while keeping the pixel timing unchanged.
//
// Request handshake: req_ready is high exactly while the engine is idle; a
// request is taken on a rising edge where req_valid and req_ready are both 1.
// req_* inputs are ignored at all other times.
module piece_draw_engine #(
    parameter logic [7:0] ORIGIN_X = 8'd20,
    parameter logic [6:0] ORIGIN_Y = 7'd20,
    parameter int         PITCH    = 8,
    parameter int         CELL     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_col,
    input  logic [2:0] req_row,
    input  logic       req_kind,
    input  logic [2:0] req_colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done,
    output logic       err,
    output logic [1:0] state_dbg
);

    localparam int NPIX = CELL * CELL;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [7:0]    base_x;
    logic [6:0]    base_y;
    logic [7:0]    req_x;
    logic [6:0]    req_y;
    logic          req_bad;

    assign req_ready = (state == IDLE);
    assign state_dbg = state;

    // Column offset of a pixel index within the square.
    function automatic logic [7:0] off_x(input logic [CW-1:0] idx);
        return 8'(int'(idx) % CELL);
    endfunction

    // Row offset of a pixel index within the square.
    function automatic logic [6:0] off_y(input logic [CW-1:0] idx);
        return 7'(int'(idx) / CELL);
    endfunction

`ifdef PIECE_ROUND_CORNERS_EN
    // Corner pixels are skipped to give the square a rounded look.
    function automatic logic pix_on(input logic [CW-1:0] idx);
        int i;
        i = int'(idx);
        return !((i == 0) || (i == CELL - 1) || (i == NPIX - CELL) || (i == NPIX - 1));
    endfunction
`else
    // Every pixel of the square is drawn.
    function automatic logic pix_on(input logic [CW-1:0] idx);
        return (idx == idx);
    endfunction
`endif

    // Request decode: square origin and range check, at full output width.
    always_comb begin
        req_x    = ORIGIN_X + 8'(req_col) * 8'(PITCH);
        req_y    = req_kind ? (ORIGIN_Y - 7'(PITCH)) : (ORIGIN_Y + 7'(req_row) * 7'(PITCH));
        req_bad  = (req_col > 3'd6) || (!req_kind && (req_row > 3'd5));
        cnt_next = cnt + 1'b1;
    end

    // Control FSM with registered pixel outputs; pixel 0 is emitted on the
    // handshake edge so the square occupies exactly NPIX cycles after it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            plot   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            base_x <= '0;
            base_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req_valid) begin
                        if (req_bad) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            base_x <= req_x;
                            base_y <= req_y;
                            colour <= req_colour;
                            x      <= req_x;
                            y      <= req_y;
                            plot   <= pix_on('0);
                            cnt    <= '0;
                            state  <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        cnt  <= cnt_next;
                        x    <= base_x + off_x(cnt_next);
                        y    <= base_y + off_y(cnt_next);
                        plot <= pix_on(cnt_next);
                    end
                end
                FINISH: begin
                    plot  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    plot  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_draw_engine.sv
// Self-checking bench for piece_draw_engine (default parameters).
// Expected pixels {cycle offset, x, y, colour} are queued when a request is
// driven and compared by the monitor whenever plot is high.
module tb_piece_draw_engine;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_kind = 1'b0;
    logic [2:0] req_col = 3'd0;
    logic [2:0] req_row = 3'd0;
    logic [2:0] req_colour = 3'd0;
    logic       req_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;
    logic       err;
    logic [1:0] state_dbg;

`ifdef PIECE_ROUND_CORNERS_EN
    localparam int PIX_PER_SQ = 12;
    localparam int SQ_GAP     = 4;
`else
    localparam int PIX_PER_SQ = 16;
    localparam int SQ_GAP     = 2;
`endif

    piece_draw_engine dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_col    (req_col),
        .req_row    (req_row),
        .req_kind   (req_kind),
        .req_colour (req_colour),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [25:0] exp_q[$];
    int          plot_cyc_q[$];
    int          hs_cyc = 0;
    int          plot_n = 0;
    int          done_n = 0;
    int          done_cyc = -1;
    logic        done_err = 1'b0;
    logic [25:0] mon_exp;
    logic [25:0] mon_got;

    // Monitor: scoreboard compare on every plotted pixel, done/err capture
    always @(negedge clk) begin
        if (resetn) begin
            if (plot === 1'b1) begin
                plot_n++;
                plot_cyc_q.push_back(cyc);
                n_checks++;
                mon_got = {8'(cyc - hs_cyc), x, y, colour};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%b, required no plot", x, y, colour);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        n_fail++;
                        $display("FAIL pixel: got off=%0d x=%0d y=%0d c=%b, required off=%0d x=%0d y=%0d c=%b",
                                 mon_got[25:18], mon_got[17:10], mon_got[9:3], mon_got[2:0],
                                 mon_exp[25:18], mon_exp[17:10], mon_exp[9:3], mon_exp[2:0]);
                    end
                end
            end
            if (done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
                done_err = err;
            end else if (err === 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL err_without_done: got err=1 done=0, required err only with done");
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Queue the expected pixels of a valid request
    function automatic void push_exp(input int col, input int row, input int kind, input logic [2:0] c);
        int bx;
        int by;
        bx = 20 + col * 8;
        by = (kind != 0) ? 12 : 20 + row * 8;
        for (int i = 0; i < 16; i++) begin
`ifdef PIECE_ROUND_CORNERS_EN
            if (i == 0 || i == 3 || i == 12 || i == 15) continue;
`endif
            exp_q.push_back({8'(i), 8'(bx + i % 4), 7'(by + i / 4), c});
        end
    endfunction

    // Drive a request and wait for its handshake; k is the handshake edge
    task automatic do_req(input int col, input int row, input int kind, input logic [2:0] c,
                          input bit hold, output int k);
        bit ok;
        ok = 1'b0;
        k  = -1;
        @(negedge clk);
        req_col    = 3'(col);
        req_row    = 3'(row);
        req_kind   = kind[0];
        req_colour = c;
        req_valid  = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                k      = cyc;
                hs_cyc = cyc;
                ok     = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hold) req_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: got no handshake in 60 cycles, required handshake");
        end
    endtask

    // Wait (bounded) until the done count exceeds d0
    task automatic wait_done(input int d0, input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            #2;
            if (done_n > d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no done in 60 cycles, required done", name);
        end
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (plot !== 1'b0)      begin n_fail++; $display("FAIL reset_plot: got %b required 0", plot); end
        n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
        n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
        n_checks++; if (x !== 8'd0)         begin n_fail++; $display("FAIL reset_x: got %0d required 0", x); end
        n_checks++; if (y !== 7'd0)         begin n_fail++; $display("FAIL reset_y: got %0d required 0", y); end
        n_checks++; if (colour !== 3'd0)    begin n_fail++; $display("FAIL reset_colour: got %b required 0", colour); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_draw(input int col, input int row, input int kind, input logic [2:0] c, input string name);
        int k;
        int d0;
        int bx;
        int by;
        bx = 20 + col * 8;
        by = (kind != 0) ? 12 : 20 + row * 8;
        plot_n = 0;
        d0 = done_n;
        push_exp(col, row, kind, c);
        do_req(col, row, kind, c, 1'b0, k);
        wait_done(d0, name);
        n_checks++; if (done_cyc - k !== 16) begin n_fail++; $display("FAIL %s_done_latency: got %0d required 16", name, done_cyc - k); end
        n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b required 0", name, done_err); end
        n_checks++; if (plot_n !== PIX_PER_SQ) begin n_fail++; $display("FAIL %s_plot_count: got %0d required %0d", name, plot_n, PIX_PER_SQ); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL %s_missing_pixels: got %0d left required 0", name, exp_q.size()); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready_after: got %b required 1", name, req_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_width: got %b required 0", name, done); end
        n_checks++;
        if (x !== 8'(bx + 3) || y !== 7'(by + 3) || colour !== c) begin
            n_fail++;
            $display("FAIL %s_hold: got x=%0d y=%0d c=%b required x=%0d y=%0d c=%b", name, x, y, colour, bx + 3, by + 3, c);
        end
        exp_q.delete();
    endtask

    task automatic test_invalid(input int col, input int row, input int kind, input string name);
        int k;
        int d0;
        plot_n = 0;
        d0 = done_n;
        do_req(col, row, kind, 3'b111, 1'b0, k);
        wait_done(d0, name);
        n_checks++; if (done_cyc !== k) begin n_fail++; $display("FAIL %s_done_latency: got %0d required 0", name, done_cyc - k); end
        n_checks++; if (done_err !== 1'b1) begin n_fail++; $display("FAIL %s_err: got %b required 1", name, done_err); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b required 1", name, req_ready); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL %s_err_width: got %b required 0", name, err); end
        repeat (3) @(negedge clk);
        n_checks++; if (plot_n !== 0) begin n_fail++; $display("FAIL %s_plots: got %0d required 0", name, plot_n); end
    endtask

    task automatic test_reset_abort();
        int k;
        int d0;
        bit hit;
        hit = 1'b0;
        plot_n = 0;
        push_exp(2, 1, 0, 3'b010);
        do_req(2, 1, 0, 3'b010, 1'b0, k);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            #2;
            if (plot_n == 5) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++; if (!hit) begin n_fail++; $display("FAIL abort_fifth_plot: got %0d plots required 5", plot_n); end
        d0 = done_n;
        resetn = 1'b0;
        @(negedge clk);
        n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL abort_plot: got %b required 0", plot); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b required 1", req_ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b required 0", done); end
        exp_q.delete();
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (done_n !== d0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_n - d0); end
        n_checks++; if (plot_n !== 5) begin n_fail++; $display("FAIL abort_no_more_plots: got %0d required 5", plot_n); end
        test_draw(2, 1, 0, 3'b010, "after_abort");
    endtask

    task automatic test_back_to_back();
        int k1;
        int k2;
        int d0;
        int gap;
        bit ok;
        ok = 1'b0;
        k2 = -1;
        plot_n = 0;
        plot_cyc_q.delete();
        d0 = done_n;
        push_exp(1, 2, 0, 3'b001);
        do_req(1, 2, 0, 3'b001, 1'b1, k1);
        req_col    = 3'd5;
        req_row    = 3'd3;
        req_kind   = 1'b0;
        req_colour = 3'b011;
        push_exp(5, 3, 0, 3'b011);
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                @(posedge clk);
                #1;
                k2     = cyc;
                hs_cyc = cyc;
                ok     = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        n_checks++; if (!ok || k2 - k1 !== 18) begin n_fail++; $display("FAIL b2b_second_handshake: got %0d required 18", k2 - k1); end
        wait_done(d0 + 1, "b2b");
        n_checks++; if (done_n - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 2", done_n - d0); end
        n_checks++; if (plot_n !== 2 * PIX_PER_SQ) begin n_fail++; $display("FAIL b2b_plot_count: got %0d required %0d", plot_n, 2 * PIX_PER_SQ); end
        gap = (plot_cyc_q.size() == 2 * PIX_PER_SQ) ? plot_cyc_q[PIX_PER_SQ] - plot_cyc_q[PIX_PER_SQ - 1] - 1 : -1;
        n_checks++; if (gap !== SQ_GAP) begin n_fail++; $display("FAIL b2b_gap: got %0d required %0d", gap, SQ_GAP); end
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_missing_pixels: got %0d left required 0", exp_q.size()); end
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_random();
        int col;
        int row;
        int kind;
        logic [2:0] c;
        for (int n = 0; n < 4; n++) begin
            col  = $urandom_range(0, 6);
            row  = $urandom_range(0, 5);
            kind = $urandom_range(0, 1);
            c    = 3'($urandom_range(0, 7));
            test_draw(col, row, kind, c, "random");
        end
    endtask

    initial begin
        test_reset();
        test_draw(0, 0, 0, 3'b100, "origin");
        test_draw(6, 5, 0, 3'b010, "far_corner");
        test_draw(3, 0, 1, 3'b001, "pointer");
        test_draw(3, 7, 1, 3'b110, "pointer_row_ignored");
        test_invalid(7, 0, 0, "bad_col");
        test_invalid(0, 6, 0, "bad_row");
        test_invalid(7, 2, 1, "bad_pointer_col");
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
